// File: rtl/apb_pkg.sv
// Shared types for the two-requester APB sequencer:
// bus phase encoding, default widths and the request bundle.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  typedef struct packed {
    logic                  wr;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_rr_arbiter_rr_arb2.sv
// Two-way round-robin picker; remembers who was granted
// last so a tie goes to the other requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elig,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  // one-hot pick, tie broken against the last winner
  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (grant_en) begin
      if (elig == 2'b11) begin
        gnt = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt = elig;
      end
    end
    if (|gnt) begin
      last_d = gnt[1];
    end
  end

  // last winner; reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Shares one APB slave path between two requesters:
// round-robin grant, SETUP/ACCESS sequencing, PREADY timeout.
module apb_rr_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT);

  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              gsel_q, gsel_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;

  logic [1:0]        elig;
  logic [1:0]        gnt;
  logic              grant_en;
  apb_req_t          sel_req;
  logic              fin;
  logic              fin_err;
  logic [DATA_W-1:0] fin_rdata;

  // a requester whose done is pulsing this cycle sits out
  assign elig     = {req1 & ~done1_q, req0 & ~done0_q};
  assign grant_en = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .elig     (elig),
    .grant_en (grant_en),
    .gnt      (gnt)
  );

  // bundle of the winning requester
  always_comb begin
    if (gnt[1]) begin
      sel_req = '{wr: wr1,
                  addr: APB_ADDR_W'(addr1),
                  wdata: APB_DATA_W'(wdata1)};
    end else begin
      sel_req = '{wr: wr0,
                  addr: APB_ADDR_W'(addr0),
                  wdata: APB_DATA_W'(wdata0)};
    end
  end

  // phase sequencing, wait counting and completion capture
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    gsel_d    = gsel_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    err0_d    = err0_q;
    err1_d    = err1_q;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = '0;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          pwrite_d = sel_req.wr;
          paddr_d  = ADDR_W'(sel_req.addr);
          pwdata_d = DATA_W'(sel_req.wdata);
          gsel_d   = gnt[1];
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        wait_d  = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          fin       = 1'b1;
          fin_err   = PSLVERR;
          fin_rdata = PRDATA;
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d = IDLE;
      if (gsel_q) begin
        done1_d = 1'b1;
        err1_d  = fin_err;
        if (!pwrite_q) rdata1_d = fin_rdata;
      end else begin
        done0_d = 1'b1;
        err0_d  = fin_err;
        if (!pwrite_q) rdata0_d = fin_rdata;
      end
    end
  end

  // state and result registers
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      gsel_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      gsel_q   <= gsel_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  assign PSEL    = (state_q != IDLE);
  assign PENABLE = (state_q == ACCESS);
  assign busy    = (state_q != IDLE);
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
Two-requester APB bus controller that sequences and shares a single APB slave path, such as the GPIO slave, between two local requesters.
- Accepts one transfer request per requester, arbitrates round-robin, and drives the SETUP/ACCESS phases.
- Waits on PREADY, bounded by a timeout, then returns read data and error status to the granted requester.
- Sits between the requester logic and the APB slave decode, in place of a single-master sequencer.

Parameters:
ADDR_W, 32, width of PADDR and requester addresses
DATA_W, 32, width of PWDATA/PRDATA and requester data
TIMEOUT, 16, max ACCESS cycles with PREADY low before abort (>=2)

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESETn  in  1  synchronous active-low reset
req0 / req1  in  1  requester n transfer request, level, held until donen
wr0 / wr1  in  1  requester n direction, 1=write, 0=read
addr0 / addr1  in  ADDR_W  requester n address
wdata0 / wdata1  in  DATA_W  requester n write data
done0 / done1  out  1  one-cycle completion pulse to requester n
rdata0 / rdata1  out  DATA_W  read data to requester n, valid with donen
err0 / err1  out  1  error flag to requester n, valid with donen
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error
busy  out  1  high whenever state != IDLE

Behaviour:
Reset (PRESETn low at a rising edge):
- state=IDLE, last_grant=1, so req0 wins the first tie.
- All outputs 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, done*, rdata*, err*, busy.
- Reset mid-transfer aborts immediately: no donen pulse, bus returns to idle the next cycle.

State machine:
- IDLE
  - Eligible requester = reqn high AND donen low in this cycle.
  - If none eligible, stay in IDLE.
  - If one eligible, grant it.
  - If both eligible, grant the requester != last_grant.
  - On grant: latch wr/addr/wdata into PWRITE/PADDR/PWDATA registers, update last_grant, go to SETUP.
- SETUP
  - PSEL=1, PENABLE=0 for exactly one cycle.
  - Then go to ACCESS and clear wait_cnt to 0.
- ACCESS
  - PSEL=1, PENABLE=1; PADDR/PWDATA/PWRITE stable from grant until return to IDLE.
  - PREADY high at an edge: capture result, go to IDLE.
    - rdata_g <= PRDATA for a read; rdata_g unchanged for a write.
    - err_g <= PSLVERR.
    - done_g = 1 in the following cycle.
  - PREADY low at an edge: wait_cnt++.
  - wait_cnt reaches TIMEOUT-1 with PREADY still low: abort and go to IDLE.
    - err_g <= 1; rdata_g <= 0 for a read.
    - done_g pulses in the following cycle.

Timing and latency:
- Minimum transfer, with PREADY high in the first ACCESS cycle:
  - req seen in IDLE at edge 0.
  - SETUP in cycle 1, ACCESS in cycle 2.
  - done in cycle 3 (IDLE).
- One IDLE cycle is always inserted between transfers, with PSEL=0.

Completion and request rules:
- done0/done1 are each high for exactly one cycle per transfer and are never high together.
- rdata/err hold their values until that requester's next completion.
- Dropping reqn while its transfer is in progress has no effect; the transfer completes and donen still pulses.
- A request from the non-granted requester arriving during SETUP/ACCESS waits; it is arbitrated at the next eligible IDLE cycle.
- PSLVERR is ignored unless PREADY is high in ACCESS.
- wait_cnt width = clog2(TIMEOUT); no wrap occurs because the abort fires first.

Decomposition:
- Shared package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS}
  - APB_ADDR_W/APB_DATA_W defaults
  - request bundle struct {wr, addr, wdata}
- One natural sub-module, rr_arb2: combinational two-way round-robin pick plus the last_grant register. Inputs: elig[1:0], grant_en. Output: gnt[1:0], one-hot.

Test Plan:
- Reset: hold PRESETn=0 for 3 cycles with req0=1 -> all outputs 0 and PSEL never asserted; first SETUP appears 1 cycle after PRESETn rises.
- Single write: req0, wr0=1, addr0=0x0000_0004, wdata0=0xDEAD_BEEF, PREADY=1 -> PSEL/PADDR=0x4 in cycle 1, PENABLE in cycle 2, done0 in cycle 3, err0=0.
- Read with wait states: req1 read addr1=0x8, PREADY low for 3 ACCESS cycles, then high with PRDATA=0x0000_00A5 -> done1 pulse with rdata1=0xA5; PADDR stable throughout.
- Contention: req0 and req1 both high continuously, 4 transfers -> grants 0,1,0,1; an IDLE cycle between each; no overlap of done pulses.
- Slave error: PSLVERR=1 with PREADY=1 on a write from req0 -> err0=1, done0 pulses; a subsequent clean transfer clears err0 to 0.
- Timeout/reset: PREADY held 0 with TIMEOUT=16 -> done pulse with err=1 and rdata=0 after 16 ACCESS cycles. Repeat with PRESETn pulled low in ACCESS cycle 5 -> no done pulse, PSEL=0 the next cycle.
